// File: rtl/i2c_master.sv
// rtl/i2c_master.sv - single-byte I2C master that loops one addressed write or read forever
// Bit periods are split into four QDIV-cycle phases; all bus outputs are registered.
module i2c_master #(
  parameter logic [6:0]  SLAVE_ADDR = 7'h50,
  parameter int unsigned QDIV       = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rw,
  inout  wire  [7:0] data,
  output logic [3:0] state,
  output logic       sclk,
  inout  wire        sda
);

  localparam int unsigned   QW        = (QDIV > 1) ? $clog2(QDIV) : 1;
  localparam logic [QW-1:0] QLAST     = QW'(QDIV - 1);
  localparam logic [7:0]    ADDR_BYTE = {SLAVE_ADDR, 1'b0};

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_START = 4'd1,
    S_ADDR  = 4'd2,
    S_RWBIT = 4'd3,
    S_AACK  = 4'd4,
    S_WDATA = 4'd5,
    S_WACK  = 4'd6,
    S_RDATA = 4'd7,
    S_RNACK = 4'd8,
    S_STOP  = 4'd9
  } state_e;

  state_e        state_q, state_d;
  logic [QW-1:0] qcnt_q, qcnt_d;
  logic [1:0]    phase_q, phase_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic          rw_q;
  logic [7:0]    wbyte_q;
  logic [7:0]    rshift_q;
  logic [7:0]    rdata_q;
  logic          ack_q;
  logic          err_q;
  logic          rd_ok_q;
  logic          sclk_q, sclk_d;
  logic          sda_oe_q, sda_oe_d;
  logic          data_oe_q;
  logic          tick, sample, bit_end, start_entry;
  logic          sda_in;

  assign sda_in = sda;
  assign sda    = sda_oe_q ? 1'b0 : 1'bz;
  assign data   = data_oe_q ? rdata_q : 8'bz;
  assign state  = state_q;
  assign sclk   = sclk_q;

  always_comb begin
    state_d = state_q;
    qcnt_d  = qcnt_q + 1'b1;
    phase_d = phase_q;
    tick    = (qcnt_q == QLAST);
    sample  = tick && (phase_q == 2'd1);
    bit_end = tick && (phase_q == 2'd3);
    if (tick) begin
      qcnt_d  = '0;
      phase_d = phase_q + 2'd1;
    end
    if (bit_end) begin
      case (state_q)
        S_IDLE:  state_d = S_START;
        S_START: state_d = S_ADDR;
        S_ADDR:  if (bitcnt_q == 3'd6) state_d = S_RWBIT;
        S_RWBIT: state_d = S_AACK;
        S_AACK:  state_d = ack_q ? S_STOP : (rw_q ? S_RDATA : S_WDATA);
        S_WDATA: if (bitcnt_q == 3'd7) state_d = S_WACK;
        S_WACK:  state_d = S_STOP;
        S_RDATA: if (bitcnt_q == 3'd7) state_d = S_RNACK;
        S_RNACK: state_d = S_STOP;
        S_STOP:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
    // Unused codes recover to IDLE at once rather than waiting for a bit boundary.
    if (state_q > S_STOP) begin
      state_d = S_IDLE;
      qcnt_d  = '0;
      phase_d = '0;
    end
    start_entry = (state_d == S_START) && (state_q != S_START);
    if (state_d != state_q) bitcnt_d = 3'd0;
    else if (bit_end)       bitcnt_d = bitcnt_q + 3'd1;
    else                    bitcnt_d = bitcnt_q;

    sclk_d   = (phase_d == 2'd1) || (phase_d == 2'd2);
    sda_oe_d = 1'b0;
    case (state_d)
      S_IDLE:  sclk_d = 1'b1;
      S_START: begin
        sclk_d   = 1'b1;
        sda_oe_d = phase_d[1];
      end
      S_ADDR:  sda_oe_d = ~ADDR_BYTE[3'd7 - bitcnt_d];
      S_RWBIT: sda_oe_d = ~rw_q;
      S_WDATA: sda_oe_d = ~wbyte_q[3'd7 - bitcnt_d];
      S_STOP: begin
        sclk_d   = (phase_d != 2'd0);
        sda_oe_d = ~phase_d[1];
      end
      default: sda_oe_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      qcnt_q    <= '0;
      phase_q   <= 2'd0;
      bitcnt_q  <= 3'd0;
      rw_q      <= 1'b0;
      wbyte_q   <= 8'd0;
      rshift_q  <= 8'd0;
      rdata_q   <= 8'd0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      rd_ok_q   <= 1'b0;
      sclk_q    <= 1'b1;
      sda_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      qcnt_q    <= qcnt_d;
      phase_q   <= phase_d;
      bitcnt_q  <= bitcnt_d;
      sclk_q    <= sclk_d;
      sda_oe_q  <= sda_oe_d;
      data_oe_q <= (state_d == S_IDLE) && rd_ok_q;
      if (start_entry) begin
        rw_q    <= rw;
        wbyte_q <= data;
        err_q   <= 1'b0;
        rd_ok_q <= 1'b0;
      end
      if (sample) begin
        if (state_q == S_AACK || state_q == S_WACK) ack_q <= sda_in;
        if (state_q == S_RDATA) rshift_q <= {rshift_q[6:0], sda_in};
      end
      if (bit_end && (state_q == S_AACK || state_q == S_WACK) && ack_q) err_q <= 1'b1;
      if (bit_end && state_q == S_RNACK) begin
        rdata_q <= rshift_q;
        rd_ok_q <= ~err_q;
      end
    end
  end

endmodule

// File: tb/tb_i2c_master.sv
// tb/tb_i2c_master.sv - bench for i2c_master: bit-period schedule model, slave emulation, directed and random transfers
module tb_i2c_master;

  localparam logic [6:0] ADDR   = 7'h50;
  localparam logic [1:0] K_BIT  = 2'd0;
  localparam logic [1:0] K_IDLE = 2'd1;
  localparam logic [1:0] K_STA  = 2'd2;
  localparam logic [1:0] K_STO  = 2'd3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rw = 1'b0;
  logic       slave_drv = 1'b0;
  logic       tb_den = 1'b0;
  logic [7:0] tb_dval = 8'h00;
  logic [3:0] state, state3;
  logic       sclk, sclk3;
  wire        sda_bus, sda_bus3;
  wire  [7:0] data_bus, data_bus3;

  always #5 clk = ~clk;

  assign sda_bus  = slave_drv ? 1'b0 : 1'bz;
  assign data_bus = tb_den ? tb_dval : 8'bz;
  pullup (sda_bus);
  pullup (sda_bus3);
  pullup (data_bus);
  pullup (data_bus3);

  i2c_master #(.SLAVE_ADDR(ADDR), .QDIV(1)) dut (
    .clk(clk), .rst(rst_n), .rw(rw), .data(data_bus),
    .state(state), .sclk(sclk), .sda(sda_bus)
  );

  i2c_master #(.SLAVE_ADDR(ADDR), .QDIV(3)) dut3 (
    .clk(clk), .rst(rst_n), .rw(rw), .data(data_bus3),
    .state(state3), .sclk(sclk3), .sda(sda_bus3)
  );

  typedef struct {
    logic       rw;
    logic [7:0] wbyte;
    logic       aack;
    logic       dack;
    logic [7:0] rbyte;
  } xfer_t;

  typedef struct {
    xfer_t      x;
    int         len_bp;
    logic [7:0] data_idle;
  } vec_t;

  typedef struct {
    logic [3:0] st;
    logic [1:0] kind;
    logic       m_bit;
    logic       s_bit;
    logic       den;
    logic [7:0] dval;
    logic [7:0] dexp;
    logic       rw_in;
    logic       rw_rand;
  } bp_t;

  int    checks = 0;
  int    failures = 0;
  xfer_t xq[$];
  bp_t   sched[$];
  int    meas_len[$];
  logic [7:0] meas_data[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " state"}, 32'(state), 32'd0);
    chk({tag, " sclk"}, 32'(sclk), 32'd1);
    chk({tag, " sda"}, 32'(sda_bus), 32'd1);
    chk({tag, " data"}, 32'(data_bus), 32'hFF);
  endtask

  function automatic bp_t mk(input logic [3:0] st, input logic [1:0] kind,
                             input logic m, input logic s, input bit rnd);
    bp_t r;
    r.st = st; r.kind = kind; r.m_bit = m; r.s_bit = s;
    r.den = rnd; r.dval = 8'($urandom);
    r.dexp = rnd ? r.dval : 8'hFF;
    r.rw_in = 1'b0; r.rw_rand = 1'b1;
    return r;
  endfunction

  // Expands the transfer list into the bit periods the bus should show after reset release.
  task automatic build(input bit rnd);
    logic       prev_ok = 1'b0;
    logic [7:0] prev_rb = 8'h00;
    logic [7:0] wb;
    bp_t        r;
    sched.delete();
    foreach (xq[i]) begin
      r = mk(4'd0, K_IDLE, 1'b1, 1'b1, 1'b0);
      r.rw_in = xq[i].rw; r.rw_rand = 1'b0;
      if (prev_ok) begin
        r.den = 1'b0; r.dexp = prev_rb;
      end else if (!xq[i].rw || rnd) begin
        r.den = 1'b1; r.dval = xq[i].wbyte; r.dexp = xq[i].wbyte;
      end
      sched.push_back(r);
      wb = prev_ok ? prev_rb : xq[i].wbyte;
      sched.push_back(mk(4'd1, K_STA, 1'b1, 1'b1, rnd));
      for (int b = 6; b >= 0; b--) sched.push_back(mk(4'd2, K_BIT, ADDR[b], 1'b1, rnd));
      sched.push_back(mk(4'd3, K_BIT, xq[i].rw, 1'b1, rnd));
      sched.push_back(mk(4'd4, K_BIT, 1'b1, !xq[i].aack, rnd));
      if (xq[i].aack) begin
        if (!xq[i].rw) begin
          for (int b = 7; b >= 0; b--) sched.push_back(mk(4'd5, K_BIT, wb[b], 1'b1, rnd));
          sched.push_back(mk(4'd6, K_BIT, 1'b1, !xq[i].dack, rnd));
        end else begin
          for (int b = 7; b >= 0; b--) sched.push_back(mk(4'd7, K_BIT, 1'b1, xq[i].rbyte[b], rnd));
          sched.push_back(mk(4'd8, K_BIT, 1'b1, 1'b1, rnd));
        end
      end
      sched.push_back(mk(4'd9, K_STO, 1'b1, 1'b1, rnd));
      prev_ok = xq[i].rw && xq[i].aack;
      prev_rb = xq[i].rbyte;
    end
    r = mk(4'd0, K_IDLE, 1'b1, 1'b1, 1'b0);
    r.dexp = prev_ok ? prev_rb : 8'hFF;
    sched.push_back(r);
  endtask

  task automatic run(input int abort_c);
    int         ncyc, bp, ph, cnt;
    bp_t        r;
    logic       exp_sclk, exp_m;
    string      tag;
    meas_len.delete();
    meas_data.delete();
    cnt = 0;
    @(posedge clk); #1;
    rst_n = 1'b0; slave_drv = 1'b0; tb_den = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("rst_hold");
    rst_n = 1'b1;
    ncyc = sched.size() * 4;
    for (int c = 0; c < ncyc; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      bp = c / 4;
      ph = c % 4;
      r  = sched[bp];
      if (c == abort_c) begin
        rst_n = 1'b0; slave_drv = 1'b0; tb_den = 1'b0;
        #1;
        chk_reset("abort");
        return;
      end
      slave_drv = !r.s_bit;
      tb_den    = r.den;
      tb_dval   = r.dval;
      rw        = r.rw_rand ? 1'($urandom) : r.rw_in;
      @(negedge clk);
      case (r.kind)
        K_IDLE:  begin exp_sclk = 1'b1;       exp_m = 1'b1;     end
        K_STA:   begin exp_sclk = 1'b1;       exp_m = (ph < 2); end
        K_STO:   begin exp_sclk = (ph != 0);  exp_m = (ph >= 2); end
        default: begin exp_sclk = (ph == 1) || (ph == 2); exp_m = r.m_bit; end
      endcase
      tag = $sformatf("c=%0d", c);
      chk({tag, " state"}, 32'(state), 32'(r.st));
      chk({tag, " sclk"}, 32'(sclk), 32'(exp_sclk));
      chk({tag, " sda"}, 32'(sda_bus), 32'(exp_m & r.s_bit));
      chk({tag, " data"}, 32'(data_bus), 32'(r.dexp));
      if (state != 4'd0) cnt++;
      else if (cnt > 0) begin
        meas_len.push_back(cnt);
        meas_data.push_back(data_bus);
        cnt = 0;
      end
    end
  endtask

  initial begin
    vec_t vecs[6];
    int   abort_c, wcount, first_rise, prev_rise, hi_run, nruns;
    logic seen_low, prev_s;

    vecs[0] = '{x: '{1'b0, 8'hA5, 1'b1, 1'b1, 8'h00}, len_bp: 20, data_idle: 8'hFF};
    vecs[1] = '{x: '{1'b1, 8'h00, 1'b1, 1'b0, 8'h3C}, len_bp: 20, data_idle: 8'h3C};
    vecs[2] = '{x: '{1'b1, 8'h00, 1'b0, 1'b0, 8'h77}, len_bp: 11, data_idle: 8'hFF};
    vecs[3] = '{x: '{1'b1, 8'h00, 1'b1, 1'b0, 8'hC3}, len_bp: 20, data_idle: 8'hC3};
    vecs[4] = '{x: '{1'b0, 8'h5A, 1'b1, 1'b0, 8'h00}, len_bp: 20, data_idle: 8'hFF};
    vecs[5] = '{x: '{1'b1, 8'h00, 1'b0, 1'b0, 8'h00}, len_bp: 11, data_idle: 8'hFF};

    xq.delete();
    foreach (vecs[i]) xq.push_back(vecs[i].x);
    build(1'b0);
    run(-1);
    foreach (vecs[i]) begin
      if (i < meas_len.size()) begin
        chk($sformatf("vec%0d len", i), 32'(meas_len[i]), 32'(vecs[i].len_bp * 4));
        chk($sformatf("vec%0d data_idle", i), 32'(meas_data[i]), 32'(vecs[i].data_idle));
      end else begin
        chk($sformatf("vec%0d transfer seen", i), 32'(meas_len.size()), 32'(i + 1));
      end
    end

    xq.delete();
    for (int i = 0; i < 12; i++)
      xq.push_back('{1'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0),
                     1'($urandom), 8'($urandom)});
    build(1'b1);
    run(-1);

    xq.delete();
    xq.push_back('{1'b0, 8'h96, 1'b1, 1'b1, 8'h00});
    build(1'b0);
    abort_c = -1;
    wcount  = 0;
    foreach (sched[i]) begin
      if (abort_c < 0 && sched[i].st == 4'd5) begin
        if (wcount == 3) abort_c = i * 4 + 1;
        wcount++;
      end
    end
    chk("abort point found", 32'(abort_c > 0), 32'd1);
    run(abort_c);
    repeat (2) @(posedge clk);
    #1;
    chk_reset("abort_hold");
    xq.delete();
    xq.push_back('{1'b0, 8'h3D, 1'b1, 1'b1, 8'h00});
    build(1'b0);
    run(-1);

    @(posedge clk); #1;
    rst_n = 1'b0; slave_drv = 1'b0; tb_den = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen_low = 1'b0; prev_s = 1'b1; hi_run = 0; nruns = 0;
    first_rise = -1; prev_rise = -1;
    for (int c = 0; c < 200 && nruns < 5; c++) begin
      @(negedge clk);
      if (sclk3) begin
        if (seen_low && !prev_s) begin
          if (first_rise < 0) begin
            first_rise = c;
            chk("q3 first rise", 32'(c), 32'd27);
          end else begin
            chk($sformatf("q3 bit period %0d", nruns), 32'(c - prev_rise), 32'd12);
          end
          prev_rise = c;
        end
        hi_run++;
      end else begin
        if (seen_low && prev_s) begin
          chk($sformatf("q3 sclk high %0d", nruns), 32'(hi_run), 32'd6);
          nruns++;
        end
        seen_low = 1'b1;
        hi_run = 0;
      end
      prev_s = sclk3;
    end
    chk("q3 high runs seen", 32'(nruns), 32'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
